// File: rtl/alu_con_unit.sv
// ALU/CON datapath slice: AND and add units, 64-bit Z result register, branch-condition flip-flop.
// Optional build macro ALU_ADD_CARRY_OUT_EN stores the adder carry-out in Z bit 32 (ZHi[0]).

module alu_adder32 (
  output logic [31:0] sum,
  output logic        cout,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin
);
  assign {cout, sum} = 33'(a) + 33'(b) + 33'(cin);
endmodule

module alu_con_unit (
  input  logic        Clock,
  input  logic        Clear,
  input  logic [31:0] Y,
  input  logic [31:0] BusMuxOut,
  input  logic        AND,
  input  logic        ADD,
  input  logic        Zin,
  input  logic [3:0]  C2,
  input  logic        CONin,
  output logic [31:0] ZHi,
  output logic [31:0] ZLo,
  output logic        BranchMet
);

  localparam int unsigned W  = 32;
  localparam int unsigned ZW = 2 * W;

`ifdef ALU_ADD_CARRY_OUT_EN
  localparam logic CARRY_EN = 1'b1;
`else
  localparam logic CARRY_EN = 1'b0;
`endif

  logic [W-1:0]  add_sum;
  logic          add_cout;
  logic [ZW-1:0] sel_res;
  logic          sel_vld;
  logic          cond;
  logic [ZW-1:0] z_d, z_q;
  logic          con_d, con_q;
  logic          unused_c2;

  alu_adder32 u_adder (
    .sum  (add_sum),
    .cout (add_cout),
    .a    (Y),
    .b    (BusMuxOut),
    .cin  (1'b0)
  );

  // Result select: AND has priority over ADD; no select means Z holds.
  always_comb begin
    sel_res = '0;
    sel_vld = 1'b0;
    if (AND) begin
      sel_res = {32'h0, Y & BusMuxOut};
      sel_vld = 1'b1;
    end else if (ADD) begin
      sel_res = {31'h0, add_cout & CARRY_EN, add_sum};
      sel_vld = 1'b1;
    end
  end

  // Branch condition decode on C2[1:0]; the upper condition bits are don't-care.
  always_comb begin
    cond = 1'b0;
    unique case (C2[1:0])
      2'b00: cond = (BusMuxOut == 32'h0);
      2'b01: cond = (BusMuxOut != 32'h0);
      2'b10: cond = ~BusMuxOut[W-1];
      2'b11: cond = BusMuxOut[W-1];
      default: cond = 1'b0;
    endcase
  end

  assign unused_c2 = ^C2[3:2];

  always_comb begin
    z_d   = z_q;
    con_d = con_q;
    if (Zin && sel_vld) z_d = sel_res;
    if (CONin)          con_d = cond;
  end

  always_ff @(posedge Clock) begin
    if (Clear) begin
      z_q   <= '0;
      con_q <= 1'b0;
    end else begin
      z_q   <= z_d;
      con_q <= con_d;
    end
  end

  assign ZHi       = z_q[ZW-1:W];
  assign ZLo       = z_q[W-1:0];
  assign BranchMet = con_q;

endmodule

// File: tb/tb_alu_con_unit.sv
// Randomised self-checking bench for alu_con_unit against a behavioural model (follows ALU_ADD_CARRY_OUT_EN).

module tb_alu_con_unit;

  logic        clk;
  logic        clr;
  logic [31:0] y, bus;
  logic        and_s, add_s, zin, conin;
  logic [3:0]  c2;
  logic [31:0] zhi, zlo;
  logic        bmet;

  logic [63:0] m_z;
  logic        m_con;
  int          n_cmp;
  int          n_err;

  alu_con_unit dut (
    .Clock     (clk),
    .Clear     (clr),
    .Y         (y),
    .BusMuxOut (bus),
    .AND       (and_s),
    .ADD       (add_s),
    .Zin       (zin),
    .C2        (c2),
    .CONin     (conin),
    .ZHi       (zhi),
    .ZLo       (zlo),
    .BranchMet (bmet)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] model_add(input logic [31:0] a, input logic [31:0] b);
    logic [63:0] s;
    s = 64'(a) + 64'(b);
`ifndef ALU_ADD_CARRY_OUT_EN
    s[63:32] = 32'h0;
`endif
    return s;
  endfunction

  function automatic logic model_cond(input logic [3:0] c, input logic [31:0] b);
    case (c[1:0])
      2'd0:    return b == 0;
      2'd1:    return b != 0;
      2'd2:    return b < 32'h8000_0000;
      default: return b >= 32'h8000_0000;
    endcase
  endfunction

  // Apply one cycle of inputs, advance the model at the edge, then compare all outputs.
  task automatic step(input logic c, input logic [31:0] a, input logic [31:0] b,
                      input logic an, input logic ad, input logic zi,
                      input logic [3:0] cc, input logic ci);
    clr = c; y = a; bus = b; and_s = an; add_s = ad; zin = zi; c2 = cc; conin = ci;
    @(posedge clk);
    if (c) begin
      m_z   = 64'h0;
      m_con = 1'b0;
    end else begin
      if (zi && an)       m_z = {32'h0, a & b};
      else if (zi && ad)  m_z = model_add(a, b);
      if (ci)             m_con = model_cond(cc, b);
    end
    #1;
    chk("zhi", 64'(zhi), 64'(m_z[63:32]));
    chk("zlo", 64'(zlo), 64'(m_z[31:0]));
    chk("bmet", 64'(bmet), 64'(m_con));
  endtask

  initial begin
    n_cmp = 0; n_err = 0;
    m_z = 64'h0; m_con = 1'b0;
    clr = 1'b1; y = '0; bus = '0; and_s = 0; add_s = 0; zin = 0; c2 = '0; conin = 0;
    @(posedge clk); #1;

    // Reset with loads requested
    step(1, 32'hDEAD_BEEF, 32'h0, 1, 0, 1, 4'h0, 1);
    chk("rst_zlo", 64'(zlo), 64'h0);
    chk("rst_bmet", 64'(bmet), 64'h0);

    // AND, then AND over ADD
    step(0, 32'hF0F0_1234, 32'h0FF0_FFFF, 1, 0, 1, 4'h0, 0);
    chk("and_lo", 64'(zlo), 64'h00F0_1234);
    chk("and_hi", 64'(zhi), 64'h0);
    step(0, 32'hFFFF_FFFF, 32'h0000_0002, 1, 1, 1, 4'h0, 0);
    chk("and_prio", 64'(zlo), 64'h0000_0002);

    // ADD with carry
    step(0, 32'hFFFF_FFFF, 32'h0000_0002, 0, 1, 1, 4'h0, 0);
    chk("addc_lo", 64'(zlo), 64'h1);
`ifdef ALU_ADD_CARRY_OUT_EN
    chk("addc_hi", 64'(zhi), 64'h1);
`else
    chk("addc_hi", 64'(zhi), 64'h0);
`endif

    // ADD without carry, then hold
    step(0, 32'd25, 32'd17, 0, 1, 1, 4'h0, 0);
    chk("add_lo", 64'(zlo), 64'd42);
    step(0, 32'd100, 32'd200, 0, 1, 0, 4'h0, 0);
    chk("hold_lo", 64'(zlo), 64'd42);
    step(0, 32'd7, 32'd8, 0, 0, 1, 4'h0, 0);
    chk("nosel_lo", 64'(zlo), 64'd42);

    // CON decode
    step(0, 32'h0, 32'h0, 0, 0, 0, 4'b0000, 1);
    chk("brzr", 64'(bmet), 64'h1);
    step(0, 32'h0, 32'h0, 0, 0, 0, 4'b0001, 1);
    chk("brnz", 64'(bmet), 64'h0);
    step(0, 32'h0, 32'h8000_0000, 0, 0, 0, 4'b0011, 1);
    chk("brmi", 64'(bmet), 64'h1);
    step(0, 32'h0, 32'h8000_0000, 0, 0, 0, 4'b1110, 1);
    chk("brpl_hi_ign", 64'(bmet), 64'h0);
    step(0, 32'h0, 32'h0, 0, 0, 0, 4'b0011, 1);
    step(0, 32'h0, 32'h8000_0000, 0, 0, 0, 4'b0011, 0);
    chk("con_hold", 64'(bmet), 64'h0);

    // Clear priority over a pending load
    step(0, 32'd1, 32'd2, 0, 1, 1, 4'b0001, 1);
    step(1, 32'hFFFF_FFFF, 32'h0000_0002, 0, 1, 1, 4'b0001, 1);
    chk("clr_prio", {zhi, zlo}, 64'h0);

    // Randomised traffic
    for (int i = 0; i < 400; i++) begin
      logic [31:0] ra, rb;
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 3))
        0: rb = 32'h0;
        1: ra = 32'hFFFF_FFFF;
        default: ;
      endcase
      step(($urandom_range(0, 19) == 0), ra, rb,
           1'($urandom), 1'($urandom), 1'($urandom), 4'($urandom), 1'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/alu_con_unit.md
# alu_con_unit

Datapath slice combining the 32-bit bitwise-AND unit, the 32-bit adder with carry, the 64-bit Z result register and the conditional-branch CON flip-flop. Operand A comes from the Y register and operand B from the shared bus. The selected result is captured into Z (ZHi/ZLo) for later bus readout. The CON logic evaluates the bus value against the IR condition field and latches the branch decision for the control unit.

## Interface

- Clock, reset: one clock; reset is synchronous and active-high. The ports are named `Clock` and `Clear`.
- No parameters.
- Clock  in  1  system clock; all state updates on the rising edge.
- Clear  in  1  synchronous active-high reset.
- Y  in  32  operand A (Y register output).
- BusMuxOut  in  32  operand B (shared bus); also the value tested by the CON logic.
- AND  in  1  select the bitwise AND result.
- ADD  in  1  select the add result.
- Zin  in  1  load enable for the Z register.
- C2  in  4  condition field, IR[22:19]; only C2[1:0] is decoded.
- CONin  in  1  load enable for the CON flip-flop.
- ZHi  out  32  Z register upper word.
- ZLo  out  32  Z register lower word.
- BranchMet  out  1  CON flip-flop output.

## Operation

**AND path**
- ZAnd = Y & BusMuxOut, bitwise, 32 bits.
- The AND result goes to the low word; the upper 32 bits of the AND result are 0.

**Add path**
- {cout, sum} = Y + BusMuxOut + 0, using unsigned 33-bit arithmetic.
- The adder is an internal submodule with ports sum[31:0], cout, a[31:0], b[31:0] and cin. cin is tied to 0 here.
- The add result is {31'b0, cout, sum}, so cout lands at bit 32 (ZHi[0]). Wrap-around is modulo 2^32 in ZLo.

**Result select**
- The select is combinational with priority: AND over ADD.
- If neither AND nor ADD is asserted, no result is selected. Zin then has no effect and Z holds.

**Z register**
- On a rising edge with Zin=1 and a valid selection, {ZHi,ZLo} ← the selected 64-bit result.
- When Zin=0, Z holds.

**CON logic**
- C2[1:0] is decoded as follows:
  - 00 brzr: cond = (BusMuxOut == 0).
  - 01 brnz: cond = (BusMuxOut != 0).
  - 10 brpl: cond = (BusMuxOut[31] == 0).
  - 11 brmi: cond = (BusMuxOut[31] == 1).
- C2[3:2] is ignored.
- On a rising edge with CONin=1, BranchMet ← cond. Otherwise BranchMet holds.

## Timing

- All result paths are combinational from Y/BusMuxOut to the register D inputs.
- One-cycle latency: the result is visible on ZHi/ZLo (or BranchMet) after the edge where Zin (or CONin) is sampled high.
- Reset values: Clear=1 at a rising edge forces ZHi=0, ZLo=0 and BranchMet=0.
- Clear has priority over Zin and CONin in the same cycle.
- Clear asserted mid-operation discards any pending load.
- Zin and CONin may be asserted in the same cycle; the two registers update independently.
- Outputs change only on rising edges. There is no combinational path from the inputs to the outputs.

## Configuration

- Macro: `ALU_ADD_CARRY_OUT_EN`.
- Defined: the add carry-out is stored at Z bit 32 (ZHi[0]), as described above.
- Not defined: the add result upper word is all zeros (ZHi=0 after an ADD load). The carry is discarded; ZLo is unchanged from the defined case.
- The AND path and CON logic are identical in both builds.

## Test plan

- Reset: drive Clear=1 for one edge with Zin=CONin=1 → ZHi=0, ZLo=0, BranchMet=0.
- AND: Y=0xF0F0_1234, Bus=0x0FF0_FFFF, AND=1, Zin=1 → ZLo=0x00F0_1234, ZHi=0. Then with AND=ADD=1 the result is still the AND result.
- ADD carry: Y=0xFFFF_FFFF, Bus=0x0000_0002, ADD=1, Zin=1 → ZLo=0x0000_0001.
  - With the macro defined, ZHi=0x0000_0001.
  - With the macro undefined, ZHi=0.
- ADD no carry, then hold: Y=25, Bus=17 → ZLo=42. Next cycle Zin=0 with changed operands → ZLo stays 42.
- CON:
  - C2=0000, Bus=0, CONin=1 → BranchMet=1.
  - C2=0001, same Bus → BranchMet=0.
  - C2=0011, Bus=0x8000_0000 → 1.
  - C2=1110, Bus=0x8000_0000 → 0 (upper bits ignored).
  - CONin=0 with changing Bus → BranchMet holds.
- Clear priority: Zin=1, ADD=1 and Clear=1 in the same cycle → ZHi=ZLo=0.
